// File: rtl/div_seq.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// returns {remainder, quotient} over a start/ready handshake with annul.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned DW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        DIV_FREE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     r_dividend;
    logic [W-1:0]      r_divisor;
    logic              r_signed;
    logic              r_neg_dvd;
    logic              r_neg_dvs;
    logic [2*W-1:0]    r_result;
    logic              r_ready;

    state_t            w_state_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DW-1:0]     w_dividend_nxt;
    logic [W-1:0]      w_divisor_nxt;
    logic              w_signed_nxt;
    logic              w_neg_dvd_nxt;
    logic              w_neg_dvs_nxt;
    logic [2*W-1:0]    w_result_nxt;
    logic              w_ready_nxt;

    logic [W-1:0]      w_abs1;
    logic [W-1:0]      w_abs2;
    logic [W:0]        w_diff;
    logic [W-1:0]      w_quo;
    logic [W-1:0]      w_rem;
    logic [W-1:0]      w_quo_fix;
    logic [W-1:0]      w_rem_fix;

    // Operand magnitudes and the trial subtraction / sign fix-up datapath.
    always_comb begin
        w_abs1 = (signed_div_i && opdata1_i[W-1]) ? W'(~opdata1_i + W'(1)) : opdata1_i;
        w_abs2 = (signed_div_i && opdata2_i[W-1]) ? W'(~opdata2_i + W'(1)) : opdata2_i;
        w_diff = {1'b0, r_dividend[2*W-1:W]} - {1'b0, r_divisor};
        w_quo  = r_dividend[W-1:0];
        w_rem  = r_dividend[2*W:W+1];
        w_quo_fix = (r_signed && (r_neg_dvd ^ r_neg_dvs)) ? W'(~w_quo + W'(1)) : w_quo;
        w_rem_fix = (r_signed && r_neg_dvd) ? W'(~w_rem + W'(1)) : w_rem;
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_signed_nxt   = r_signed;
        w_neg_dvd_nxt  = r_neg_dvd;
        w_neg_dvs_nxt  = r_neg_dvs;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;

        case (r_state)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    w_signed_nxt   = signed_div_i;
                    w_neg_dvd_nxt  = signed_div_i && opdata1_i[W-1];
                    w_neg_dvs_nxt  = signed_div_i && opdata2_i[W-1];
                    w_divisor_nxt  = w_abs2;
                    w_dividend_nxt = {{W{1'b0}}, w_abs1, 1'b0};
                    w_cnt_nxt      = '0;
                    w_state_nxt    = (opdata2_i == '0) ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                if (annul_i) begin
                    w_state_nxt = DIV_FREE;
                end else begin
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = DIV_END;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    w_state_nxt = DIV_FREE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != CW'(W)) begin
                    if (w_diff[W]) begin
                        w_dividend_nxt = {r_dividend[DW-2:0], 1'b0};
                    end else begin
                        w_dividend_nxt = {w_diff[W-1:0], r_dividend[W-1:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + CW'(1);
                end else begin
                    w_result_nxt = {w_rem_fix, w_quo_fix};
                    w_ready_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = DIV_END;
                end
            end
            DIV_END: begin
                // Result is held until the requester releases start_i.
                if (!start_i) begin
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                    w_state_nxt  = DIV_FREE;
                end
            end
            default: w_state_nxt = DIV_FREE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_signed   <= 1'b0;
            r_neg_dvd  <= 1'b0;
            r_neg_dvs  <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_signed   <= w_signed_nxt;
            r_neg_dvd  <= w_neg_dvd_nxt;
            r_neg_dvs  <= w_neg_dvs_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state == DIV_ZERO) || (r_state == DIV_ON);

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq with hand-computed results.
`timescale 1ns/1ps
module tb_div_seq;
    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check busy, latency in edges after accept, result and hold/release.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int exp_edges, input int hold);
        int k;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        step();
        check({tag, "_busy_after_accept"}, 64'(busy_o), 64'd1);
        opdata1_i    = ~a;
        opdata2_i    = 32'h0000_0003;
        signed_div_i = ~s;
        k = 0;
        while (!ready_o && k < 100) begin
            step();
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(exp_edges));
        check({tag, "_result"}, result_o, exp_res);
        check({tag, "_busy_at_end"}, 64'(busy_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check($sformatf("%s_hold%0d", tag, i), {63'd0, ready_o}, 64'd1);
        end
        start_i = 1'b0;
        step();
        check({tag, "_release_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_release_result"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        step();
        step();
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        step();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
        step();
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 0);
        run_div("divu_zero", 1'b0, 32'd5, 32'd0, 64'd0, 1, 5);

        // Annul together with start in the free state: request is refused.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd8;
        opdata2_i    = 32'd2;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        step();
        check("annul_with_start_busy", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        step();

        // Annul at iteration 10 of 50/3.
        opdata1_i = 32'd50;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        annul_i = 1'b1;
        start_i = 1'b0;
        step();
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen++;
            step();
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_div("divu_9_4", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33, 0);

        // Synchronous reset mid-division.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        step();
        for (int i = 0; i < 19; i++) step();
        rst = 1'b1;
        step();
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        step();
        run_div("after_rst", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
